fetch_stage: RTL and testbench

- Instruction-fetch front end feeding the IF/ID pipeline register of the 5-stage RV32I pipeline.
- Owns the fetch PC and issues word requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned instructions in a small prefetch queue.
- Obeys StallF from the hazard unit and redirects on PCSrcE/PCTargetE, discarding wrong-path fetches.

---
 rtl/fetch_stage.sv | 222 ++++++++++++++++++++++
 tb/tb_fetch_stage.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Purpose : RV32I instruction-fetch front end; owns the fetch PC, issues imem word requests, buffers replies in a prefetch queue.
// Latency : imem_rvalid -> InstrValidF is 1 cycle; InstrF/PCF/PCPlus4F are combinational from the queue head.
// Backpr. : StallF holds the head; new requests are issued only while queue entries plus live in-flight requests are below QDEPTH.
//
// Ports:
//   clk, reset            rising-edge clock; asynchronous active-low reset
//   StallF                hold the current head instruction
//   PCSrcE, PCTargetE     redirect request from Execute and its target (bits [1:0] ignored)
//   imem_req/addr/gnt     request side of the instruction-memory handshake
//   imem_rvalid/rdata     in-order read responses, at least one cycle after gnt
//   InstrF, PCF, PCPlus4F head instruction (NOP when empty), its PC, PC + 4
//   InstrValidF           queue non-empty; 0 is a bubble to Decode
//
// Optional build macro FETCH_PERF_EN adds saturating bubble_count and
// redirect_count outputs. Without it the ports and counters do not exist.

module fetch_stage #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000,
    parameter int               QDEPTH   = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StallF,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     InstrF,
    output logic [XLEN-1:0] PCF,
    output logic [XLEN-1:0] PCPlus4F,
    output logic            InstrValidF
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     bubble_count,
    output logic [31:0]     redirect_count
`endif
);

    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;
    // Outstanding and drop counters are wider than QDEPTH alone would need:
    // back-to-back redirects against a slow memory leave wrong-path requests
    // in flight while fresh ones are issued, so the in-flight total can
    // exceed QDEPTH even though the live (kept) portion never does.
    localparam int OW = 8;

    localparam logic [31:0]     NOP  = 32'h0000_0013;
    localparam logic [XLEN-1:0] FOUR = XLEN'(4);

    // Prefetch queue storage and pointers
    logic [XLEN-1:0] q_pc_q    [QDEPTH];
    logic [XLEN-1:0] q_pc_d    [QDEPTH];
    logic [31:0]     q_instr_q [QDEPTH];
    logic [31:0]     q_instr_d [QDEPTH];
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q,  count_d;

    // PC tracking and in-flight bookkeeping
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q,  resp_pc_d;
    logic [OW-1:0]   outst_q,    outst_d;
    logic [OW-1:0]   drop_q,     drop_d;

    logic [OW:0]     credit_used;
    logic [OW-1:0]   outst_post;
    logic [XLEN-1:0] target_aligned;
    logic            req_int;
    logic            hs;
    logic            push;
    logic            pop;
    logic            head_vld;

    assign target_aligned = {PCTargetE[XLEN-1:2], 2'b00};
    assign head_vld       = (count_q != '0);

    // Live entries = queued + in-flight responses that will actually be kept.
    // Responses already marked for dropping do not consume a queue slot.
    assign credit_used = (OW+1)'(count_q) + (OW+1)'(outst_q) - (OW+1)'(drop_q);

    // The all-ones guard on outst_q keeps the in-flight counter from wrapping
    // under a pathological storm of redirects; it never binds in normal use.
    assign req_int = (credit_used < (OW+1)'(QDEPTH)) && (outst_q != '1) && !PCSrcE;

    // Gate with reset so no request is presented while the block is held.
    assign imem_req  = req_int & reset;
    assign imem_addr = fetch_pc_q;
    assign hs        = imem_req & imem_gnt;

    // Head outputs. With an empty queue PCF shows the PC of the next
    // expected instruction so it is well defined (RESET_PC out of reset).
    always_comb begin
        InstrValidF = head_vld;
        InstrF      = NOP;
        PCF         = resp_pc_q;
        if (head_vld) begin
            InstrF = q_instr_q[rd_ptr_q];
            PCF    = q_pc_q[rd_ptr_q];
        end
        PCPlus4F = PCF + FOUR;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        q_pc_d     = q_pc_q;
        q_instr_d  = q_instr_q;
        push       = 1'b0;
        pop        = 1'b0;

        // In-flight count after this cycle's grant and response.
        outst_post = outst_q + OW'(hs) - OW'(imem_rvalid);

        if (PCSrcE) begin
            // Redirect wins over everything: flush the queue and mark every
            // request still in flight as wrong-path. A response arriving
            // now is already excluded from outst_post and is simply dropped.
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            fetch_pc_d = target_aligned;
            resp_pc_d  = target_aligned;
            outst_d    = outst_post;
            drop_d     = outst_post;
        end else begin
            outst_d = outst_post;

            if (hs) begin
                fetch_pc_d = fetch_pc_q + FOUR;
            end

            if (imem_rvalid) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - OW'(1);
                end else begin
                    push                = 1'b1;
                    q_pc_d[wr_ptr_q]    = resp_pc_q;
                    q_instr_d[wr_ptr_q] = imem_rdata;
                    wr_ptr_d            = wr_ptr_q + AW'(1);
                    resp_pc_d           = resp_pc_q + FOUR;
                end
            end

            if (head_vld && !StallF) begin
                pop      = 1'b1;
                rd_ptr_d = rd_ptr_q + AW'(1);
            end

            // Push into a full queue is only possible alongside a pop, so
            // the count never exceeds QDEPTH.
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                q_pc_q[i]    <= '0;
                q_instr_q[i] <= NOP;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            for (int i = 0; i < QDEPTH; i++) begin
                q_pc_q[i]    <= q_pc_d[i];
                q_instr_q[i] <= q_instr_d[i];
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] bubble_count_q,   bubble_count_d;
    logic [31:0] redirect_count_q, redirect_count_d;

    // Both counters saturate rather than wrap so long runs stay meaningful.
    always_comb begin
        bubble_count_d   = bubble_count_q;
        redirect_count_d = redirect_count_q;
        if (!head_vld && (bubble_count_q != 32'hFFFF_FFFF)) begin
            bubble_count_d = bubble_count_q + 32'd1;
        end
        if (PCSrcE && (redirect_count_q != 32'hFFFF_FFFF)) begin
            redirect_count_d = redirect_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bubble_count_q   <= '0;
            redirect_count_q <= '0;
        end else begin
            bubble_count_q   <= bubble_count_d;
            redirect_count_q <= redirect_count_d;
        end
    end

    assign bubble_count   = bubble_count_q;
    assign redirect_count = redirect_count_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Purpose : self-checking bench for fetch_stage against a stream-level reference model.
// Latency : one clock per cycle() call; inputs driven just after posedge, outputs checked at negedge.
// Backpr. : random grant/response/stall/redirect; memory model answers in order with latency >= 1.

module tb_fetch_stage;

    localparam int          QDEPTH = 2;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallF, PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] InstrF, PCF, PCPlus4F;
    logic        InstrValidF;

    // Second instance: RESET_PC near the top of the address space, always granted.
    logic        w_req, w_rvalid, w_vld;
    logic [31:0] w_addr, w_rdata, w_instr, w_pcf, w_pc4;

`ifdef FETCH_PERF_EN
    logic [31:0] bubble_count, redirect_count, w_bubble, w_redir;
`endif

    always #5 clk = ~clk;

    fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000), .QDEPTH(QDEPTH)) u_dut (
        .clk(clk), .reset(reset), .StallF(StallF), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F), .InstrValidF(InstrValidF)
`ifdef FETCH_PERF_EN
        , .bubble_count(bubble_count), .redirect_count(redirect_count)
`endif
    );

    fetch_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .QDEPTH(QDEPTH)) u_wrap (
        .clk(clk), .reset(reset), .StallF(1'b0), .PCSrcE(1'b0), .PCTargetE(32'h0),
        .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(1'b1),
        .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
        .InstrF(w_instr), .PCF(w_pcf), .PCPlus4F(w_pc4), .InstrValidF(w_vld)
`ifdef FETCH_PERF_EN
        , .bubble_count(w_bubble), .redirect_count(w_redir)
`endif
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Memory contents: a fixed scramble of the address so PC/data swaps show up.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    typedef struct {
        logic [31:0] addr;
        int          cyc;
    } mreq_t;

    mreq_t       mq[$];
    int          cyc = 0;
    int          p_gnt = 100;
    int          p_rv  = 100;

    // Reference model: the next PC Decode must see, the next address that
    // must be requested, and the number of live words (granted since the
    // last redirect and not yet consumed by Decode).
    logic [31:0] exp_pc, exp_req;
    int          live;
    int          pops = 0;

    // Wrap-instance helpers
    logic        w_pend;
    logic [31:0] w_pend_addr;
    logic [31:0] w_seen[$];
    logic        last_vld;
    logic [31:0] last_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] w_bub_first;
`endif

    task automatic cycle(input logic st, input logic rd, input logic [31:0] tgt);
        mreq_t h;
        StallF      = st;
        PCSrcE      = rd;
        PCTargetE   = tgt;
        imem_gnt    = ($urandom_range(99) < p_gnt);
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        if (mq.size() > 0 && mq[0].cyc < cyc && $urandom_range(99) < p_rv) begin
            h           = mq.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(h.addr);
        end
        w_rvalid = w_pend;
        w_rdata  = mem_word(w_pend_addr);

        @(negedge clk);

        if (InstrValidF) begin
            chk("head_pc", PCF, exp_pc);
            chk("head_instr", InstrF, mem_word(PCF));
            chk("pc_plus4", PCPlus4F, PCF + 32'd4);
        end else begin
            chk("nop_when_empty", InstrF, NOP);
        end
        chk("req_credit", {31'd0, imem_req}, {31'd0, (live < QDEPTH) && !rd});
        if (imem_req) chk("req_addr", imem_addr, exp_req);

        if (w_vld) begin
            chk("wrap_instr", w_instr, mem_word(w_pcf));
`ifdef FETCH_PERF_EN
            if (w_seen.size() == 0) w_bub_first = w_bubble;
`endif
            w_seen.push_back(w_pcf);
        end
        w_pend      = w_req;
        w_pend_addr = w_addr;

        last_vld = InstrValidF;
        last_pc  = PCF;

        if (imem_req && imem_gnt) mq.push_back('{imem_addr, cyc});
        if (rd) begin
            exp_pc  = {tgt[31:2], 2'b00};
            exp_req = {tgt[31:2], 2'b00};
            live    = 0;
        end else begin
            if (imem_req && imem_gnt) begin
                exp_req += 32'd4;
                live++;
            end
            if (InstrValidF && !st) begin
                exp_pc += 32'd4;
                live--;
                pops++;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        StallF      = 1'b0;
        PCSrcE      = 1'b0;
        PCTargetE   = 32'h0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        w_rvalid    = 1'b0;
        w_rdata     = 32'h0;
        w_pend      = 1'b0;
        w_pend_addr = 32'h0;
        mq.delete();
        w_seen.delete();
        repeat (2) @(negedge clk);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_vld", {31'd0, InstrValidF}, 32'd0);
        chk("rst_instr", InstrF, NOP);
        chk("rst_pcf", PCF, 32'h0);
        chk("rst_pc4", PCPlus4F, 32'h4);
        chk("rst_wrap_pcf", w_pcf, 32'hFFFF_FFF8);
        chk("rst_wrap_pc4", w_pc4, 32'hFFFF_FFFC);
`ifdef FETCH_PERF_EN
        chk("rst_bubble", bubble_count, 32'd0);
        chk("rst_redir", redirect_count, 32'd0);
`endif
        @(posedge clk);
        #1;
        reset   = 1'b1;
        exp_pc  = 32'h0;
        exp_req = 32'h0;
        live    = 0;
    endtask

    // Release: grants every cycle, responses one cycle later.
    task automatic release_check();
        logic v[3];
        logic [31:0] pc2;
        p_gnt = 100;
        p_rv  = 100;
        pc2   = 32'hFFFF_FFFF;
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b0, 32'h0);
            v[k] = last_vld;
            if (k == 2) pc2 = last_pc;
        end
        chk("rel_vld_c0", {31'd0, v[0]}, 32'd0);
        chk("rel_vld_c1", {31'd0, v[1]}, 32'd0);
        chk("rel_vld_c2", {31'd0, v[2]}, 32'd1);
        chk("rel_first_pc", pc2, 32'h0);
        repeat (6) cycle(1'b0, 1'b0, 32'h0);
        chk("wrap_seen_n", {31'd0, w_seen.size() >= 3}, 32'd1);
        if (w_seen.size() >= 3) begin
            chk("wrap_pc0", w_seen[0], 32'hFFFF_FFF8);
            chk("wrap_pc1", w_seen[1], 32'hFFFF_FFFC);
            chk("wrap_pc2", w_seen[2], 32'h0000_0000);
        end
`ifdef FETCH_PERF_EN
        chk("wrap_bubble_first", w_bub_first, 32'd2);
`endif
    endtask

    initial begin
        reset = 1'b1;
        @(posedge clk);
        #1;
        do_reset();
        release_check();

        // Hold the head for three cycles, then release.
        repeat (3) cycle(1'b1, 1'b0, 32'h0);
        repeat (3) cycle(1'b0, 1'b0, 32'h0);

        // Build up in-flight requests with no responses, then redirect.
        p_rv = 0;
        repeat (3) cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 32'h0000_0100);
        p_rv = 100;
        repeat (8) cycle(1'b0, 1'b0, 32'h0);

        // Withhold grants: address must stay put while the queue drains.
        p_gnt = 0;
        repeat (4) cycle(1'b0, 1'b0, 32'h0);
        p_gnt = 100;
        repeat (4) cycle(1'b0, 1'b0, 32'h0);

        // Redirect while a response and a grant are both in progress.
        repeat (2) cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 32'h0000_0043);
        repeat (6) cycle(1'b0, 1'b0, 32'h0);

        // Randomized traffic, with a reset in the middle.
        for (int phase = 0; phase < 2; phase++) begin
            for (int blk = 0; blk < 8; blk++) begin
                p_gnt = 20 + $urandom_range(80);
                p_rv  = 20 + $urandom_range(80);
                for (int i = 0; i < 100; i++) begin
                    cycle($urandom_range(3) == 0, $urandom_range(19) == 0, $urandom);
                end
            end
            if (phase == 0) begin
                do_reset();
                release_check();
            end
        end

        // Wrap-around of a redirect target.
        p_gnt = 100;
        p_rv  = 100;
        cycle(1'b0, 1'b1, 32'hFFFF_FFFE);
        repeat (10) cycle(1'b0, 1'b0, 32'h0);

        chk("progress", {31'd0, pops > 200}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
